// File: rtl/rv32i_single_cycle_top.sv
// rv32i_single_cycle_top: single-cycle RV32I core with internal instruction ROM and data RAM
module rv32i_single_cycle_top #(
  parameter int    IMEM_WORDS = 256,
  parameter int    DMEM_WORDS = 256,
  parameter string IMEM_INIT  = "program.mem"
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  output logic        wb_en_out,
  output logic [4:0]  wb_addr_out,
  output logic [31:0] wb_data_out
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];
  logic [31:0] pc, pc4, pc_next, instr, rs1v, rs2v;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu, ea, word, ld, wb_data;
  logic [15:0] lhalf;
  logic [7:0]  lbyte;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [3:0]  sel;
  logic [2:0]  f3;
  logic        is_op, is_opimm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic        eq, lt, ltu, taken, wb_en, unused_ok;
  assign instr = imem[pc[IW+1:2]];
  assign op  = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign is_op     = op == 7'h33;
  assign is_opimm  = op == 7'h13;
  assign is_load   = op == 7'h03;
  assign is_store  = op == 7'h23;
  assign is_branch = op == 7'h63;
  assign is_jal    = op == 7'h6f;
  assign is_jalr   = op == 7'h67;
  assign is_lui    = op == 7'h37;
  assign is_auipc  = op == 7'h17;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1v = rs1 == 5'd0 ? '0 : regs[rs1];
  assign rs2v = rs2 == 5'd0 ? '0 : regs[rs2];
  // inst[30] selects sub/sra for OP, but only srai among the immediate forms
  assign alu_b = is_op ? rs2v : imm_i;
  assign sel   = {f3, (is_op | f3 == 3'b101) & instr[30]};
  always_comb begin
    case (sel)
      4'b0001: alu = rs1v - alu_b;
      4'b0010: alu = rs1v << alu_b[4:0];
      4'b0100: alu = {31'b0, $signed(rs1v) < $signed(alu_b)};
      4'b0110: alu = {31'b0, rs1v < alu_b};
      4'b1000: alu = rs1v ^ alu_b;
      4'b1010: alu = rs1v >> alu_b[4:0];
      4'b1011: alu = $signed(rs1v) >>> alu_b[4:0];
      4'b1100: alu = rs1v | alu_b;
      4'b1110: alu = rs1v & alu_b;
      default: alu = rs1v + alu_b;
    endcase
  end
  assign ea    = rs1v + (is_store ? imm_s : imm_i);
  assign word  = dmem[ea[DW+1:2]];
  assign lbyte = word[{ea[1:0], 3'b000} +: 8];
  assign lhalf = ea[1] ? word[31:16] : word[15:0];
  assign ld = f3 == 3'b000 ? {{24{lbyte[7]}}, lbyte} :
              f3 == 3'b001 ? {{16{lhalf[15]}}, lhalf} :
              f3 == 3'b100 ? {24'b0, lbyte} :
              f3 == 3'b101 ? {16'b0, lhalf} : word;
  assign eq    = rs1v == rs2v;
  assign lt    = $signed(rs1v) < $signed(rs2v);
  assign ltu   = rs1v < rs2v;
  assign taken = is_branch & (f3[2:1] != 2'b01) & ((f3[2] ? (f3[1] ? ltu : lt) : eq) ^ f3[0]);
  assign pc4     = pc + 32'd4;
  assign pc_next = is_jal ? pc + imm_j : is_jalr ? {ea[31:1], 1'b0} : taken ? pc + imm_b : pc4;
  assign wb_en   = (rd != 5'd0) & (is_op | is_opimm | is_lui | is_auipc | is_load | is_jal | is_jalr);
  assign wb_data = is_load ? ld : (is_jal | is_jalr) ? pc4 : is_lui ? imm_u : is_auipc ? pc + imm_u : alu;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else begin
      pc <= pc_next;
      if (wb_en) regs[rd] <= wb_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && is_store) begin
      if (f3 == 3'b000) dmem[ea[DW+1:2]][{ea[1:0], 3'b000} +: 8] <= rs2v[7:0];
      else if (f3 == 3'b001) dmem[ea[DW+1:2]][{ea[1], 4'b0000} +: 16] <= rs2v[15:0];
      else if (f3 == 3'b010) dmem[ea[DW+1:2]] <= rs2v;
    end
  end
  assign unused_ok   = ^ea[31:DW+2];
  assign pc_out      = pc;
  assign wb_en_out   = wb_en;
  assign wb_addr_out = rd;
  assign wb_data_out = wb_data;
endmodule

// File: tb/tb_rv32i_single_cycle_top.sv
// tb_rv32i_single_cycle_top: directed programs with a per-cycle retire-trace scoreboard
module tb_rv32i_single_cycle_top;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] pc_out, wb_data_out;
  logic        wb_en_out;
  logic [4:0]  wb_addr_out;
  typedef struct packed {
    logic [31:0] pc;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] d;
  } rec_t;
  rec_t        q[$];
  string       tags[$];
  logic [31:0] img [256];
  int          total = 0;
  int          bad = 0;
  localparam logic [31:0] NOP = 32'h00000013;
  rv32i_single_cycle_top #(.IMEM_WORDS(256), .DMEM_WORDS(256), .IMEM_INIT("")) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .wb_en_out(wb_en_out),
    .wb_addr_out(wb_addr_out), .wb_data_out(wb_data_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] j_t(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  task automatic clr();
    for (int i = 0; i < 256; i++) img[i] = NOP;
  endtask
  task automatic put(int addr, logic [31:0] ins);
    img[addr/4] = ins;
  endtask
  task automatic ex(string tag, logic [31:0] pc, logic en, int rd, logic [31:0] d);
    logic [4:0] r;
    r = rd[4:0];
    q.push_back('{pc: pc, en: en, rd: en ? r : 5'd0, d: en ? d : 32'd0});
    tags.push_back(tag);
  endtask
  task automatic run(int n);
    for (int i = 0; i < 256; i++) dut.imem[i] = img[i];
    @(posedge clk);
    #1 rst = 0;
    repeat (n) @(posedge clk);
    #1 rst = 1;
  endtask
  always @(negedge clk) begin
    rec_t e, a;
    string t;
    if (!rst) begin
      total++;
      a = '{pc: pc_out, en: wb_en_out, rd: wb_en_out ? wb_addr_out : 5'd0, d: wb_en_out ? wb_data_out : 32'd0};
      if (q.size() == 0) begin
        bad++;
        $display("FAIL underflow: got pc=%h en=%b rd=%0d d=%h, expected no retire", a.pc, a.en, a.rd, a.d);
      end else begin
        e = q.pop_front();
        t = tags.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got pc=%h en=%b rd=%0d d=%h, want pc=%h en=%b rd=%0d d=%h",
                   t, a.pc, a.en, a.rd, a.d, e.pc, e.en, e.rd, e.d);
        end
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    clr();
    put('h00, i_t(-5, 0, 0, 1, 'h13));        ex("addi_neg", 'h00, 1, 1, 32'hFFFFFFFB);
    put('h04, i_t(3, 0, 0, 2, 'h13));         ex("addi_pos", 'h04, 1, 2, 32'h00000003);
    put('h08, r_t('h20, 2, 1, 0, 3));         ex("sub",      'h08, 1, 3, 32'hFFFFFFF8);
    put('h0C, r_t(0, 2, 1, 1, 3));            ex("sll",      'h0C, 1, 3, 32'hFFFFFFD8);
    put('h10, r_t(0, 2, 1, 2, 3));            ex("slt",      'h10, 1, 3, 32'h00000001);
    put('h14, r_t(0, 2, 1, 3, 3));            ex("sltu",     'h14, 1, 3, 32'h00000000);
    put('h18, r_t(0, 2, 1, 4, 3));            ex("xor",      'h18, 1, 3, 32'hFFFFFFF8);
    put('h1C, r_t(0, 2, 1, 5, 3));            ex("srl",      'h1C, 1, 3, 32'h1FFFFFFF);
    put('h20, r_t('h20, 2, 1, 5, 3));         ex("sra",      'h20, 1, 3, 32'hFFFFFFFF);
    put('h24, r_t(0, 2, 1, 6, 3));            ex("or",       'h24, 1, 3, 32'hFFFFFFFB);
    put('h28, r_t(0, 2, 1, 7, 3));            ex("and",      'h28, 1, 3, 32'h00000003);
    put('h2C, r_t(0, 2, 1, 0, 3));            ex("add",      'h2C, 1, 3, 32'hFFFFFFFE);
    put('h30, i_t('h400, 0, 0, 6, 'h13));     ex("addi_b30", 'h30, 1, 6, 32'h00000400);
    put('h34, i_t('h401, 1, 5, 7, 'h13));     ex("srai",     'h34, 1, 7, 32'hFFFFFFFD);
    put('h38, i_t(28, 1, 5, 7, 'h13));        ex("srli",     'h38, 1, 7, 32'h0000000F);
    put('h3C, i_t(31, 2, 1, 7, 'h13));        ex("slli",     'h3C, 1, 7, 32'h80000000);
    put('h40, i_t(-4, 1, 2, 8, 'h13));        ex("slti",     'h40, 1, 8, 32'h00000001);
    put('h44, i_t(-1, 2, 3, 8, 'h13));        ex("sltiu",    'h44, 1, 8, 32'h00000001);
    put('h48, i_t(-1, 1, 4, 8, 'h13));        ex("xori",     'h48, 1, 8, 32'h00000004);
    put('h4C, i_t('hF0, 1, 7, 8, 'h13));      ex("andi",     'h4C, 1, 8, 32'h000000F0);
    put('h50, i_t('h100, 2, 6, 8, 'h13));     ex("ori",      'h50, 1, 8, 32'h00000103);
    run(21);
    clr();
    put('h00, u_t('h80FF8, 1, 'h37));         ex("lui_hi",   'h00, 1, 1, 32'h80FF8000);
    put('h04, i_t(-255, 1, 0, 1, 'h13));      ex("addi_lo",  'h04, 1, 1, 32'h80FF7F01);
    put('h08, s_t(8, 1, 0, 2));               ex("sw",       'h08, 0, 0, 0);
    put('h0C, i_t(8, 0, 0, 3, 'h03));         ex("lb8",      'h0C, 1, 3, 32'h00000001);
    put('h10, i_t(11, 0, 0, 3, 'h03));        ex("lb11",     'h10, 1, 3, 32'hFFFFFF80);
    put('h14, i_t(11, 0, 4, 3, 'h03));        ex("lbu11",    'h14, 1, 3, 32'h00000080);
    put('h18, i_t(10, 0, 1, 3, 'h03));        ex("lh10",     'h18, 1, 3, 32'hFFFF80FF);
    put('h1C, i_t(10, 0, 5, 3, 'h03));        ex("lhu10",    'h1C, 1, 3, 32'h000080FF);
    put('h20, i_t('hAA, 0, 0, 2, 'h13));      ex("addi_aa",  'h20, 1, 2, 32'h000000AA);
    put('h24, s_t(9, 2, 0, 0));               ex("sb9",      'h24, 0, 0, 0);
    put('h28, i_t(8, 0, 2, 3, 'h03));         ex("lw_sb",    'h28, 1, 3, 32'h80FFAA01);
    put('h2C, i_t(8, 0, 0, 4, 'h13));         ex("addi_b",   'h2C, 1, 4, 32'h00000008);
    put('h30, s_t(2, 2, 4, 1));               ex("sh10",     'h30, 0, 0, 0);
    put('h34, i_t(0, 4, 2, 3, 'h03));         ex("lw_sh",    'h34, 1, 3, 32'h00AAAA01);
    put('h38, i_t(11, 0, 1, 3, 'h03));        ex("lh11",     'h38, 1, 3, 32'h000000AA);
    put('h3C, i_t('h40B, 0, 2, 3, 'h03));     ex("lw_wrap",  'h3C, 1, 3, 32'h00AAAA01);
    put('h40, i_t(10, 0, 0, 3, 'h03));        ex("lb10",     'h40, 1, 3, 32'hFFFFFFAA);
    put('h44, s_t(9, 1, 0, 1));               ex("sh9",      'h44, 0, 0, 0);
    put('h48, i_t(8, 0, 5, 3, 'h03));         ex("lhu8",     'h48, 1, 3, 32'h00007F01);
    put('h4C, i_t(8, 0, 2, 3, 'h03));         ex("lw_sh9",   'h4C, 1, 3, 32'h00AA7F01);
    run(20);
    clr();
    put('h00, i_t(-1, 0, 0, 1, 'h13));        ex("br_x1",    'h00, 1, 1, 32'hFFFFFFFF);
    put('h04, i_t(1, 0, 0, 2, 'h13));         ex("br_x2",    'h04, 1, 2, 32'h00000001);
    put('h08, b_t(8, 2, 1, 0));               ex("beq",      'h08, 0, 0, 0);
    put('h0C, b_t(8, 2, 1, 1));               ex("bne",      'h0C, 0, 0, 0);
    put('h10, i_t(99, 0, 0, 9, 'h13));
    put('h14, b_t(8, 2, 1, 4));               ex("blt",      'h14, 0, 0, 0);
    put('h18, i_t(99, 0, 0, 9, 'h13));
    put('h1C, b_t(8, 2, 1, 5));               ex("bge",      'h1C, 0, 0, 0);
    put('h20, b_t(8, 2, 1, 6));               ex("bltu",     'h20, 0, 0, 0);
    put('h24, b_t(8, 2, 1, 7));               ex("bgeu",     'h24, 0, 0, 0);
    put('h28, i_t(99, 0, 0, 9, 'h13));
    put('h2C, i_t(7, 0, 0, 3, 'h13));         ex("br_land",  'h2C, 1, 3, 32'h00000007);
    put('h30, b_t(-48, 0, 0, 0));             ex("beq_back", 'h30, 0, 0, 0);
                                              ex("br_loop",  'h00, 1, 1, 32'hFFFFFFFF);
    run(11);
    clr();
    for (int i = 0; i < 8; i++) ex("nop", i * 4, 0, 0, 0);
    put('h20, j_t(16, 1));                    ex("jal",      'h20, 1, 1, 32'h00000024);
    put('h30, i_t(3, 1, 0, 5, 'h67));         ex("jalr",     'h30, 1, 5, 32'h00000034);
    put('h24, i_t(1, 0, 0, 6, 'h13));         ex("at_26",    'h26, 1, 6, 32'h00000001);
    put('h28, u_t('h12345, 4, 'h37));         ex("lui",      'h2A, 1, 4, 32'h12345000);
    put('h2C, i_t(5, 0, 0, 0, 'h13));         ex("x0_write", 'h2E, 0, 0, 0);
    run(13);
    clr();
    put('h00, r_t(0, 5, 1, 0, 7));            ex("rst_regs", 'h00, 1, 7, 32'h00000000);
    put('h04, j_t('h3C, 0));                  ex("jal_x0",   'h04, 0, 0, 0);
    put('h40, u_t(1, 4, 'h17));               ex("auipc",    'h40, 1, 4, 32'h00001040);
    put('h44, i_t(8, 0, 2, 8, 'h03));         ex("dmem_keep",'h44, 1, 8, 32'h00AA7F01);
    put('h48, r_t(0, 4, 6, 0, 9));            ex("rst_x6",   'h48, 1, 9, 32'h00001040);
    put('h4C, 32'h00000073);                  ex("ecall",    'h4C, 0, 0, 0);
    put('h50, 32'h0000000F);                  ex("fence",    'h50, 0, 0, 0);
    put('h54, 32'hFFFFFFFF);                  ex("unknown",  'h54, 0, 0, 0);
    put('h58, j_t(-'h58, 10));                ex("jal_back", 'h58, 1, 10, 32'h0000005C);
                                              ex("wrap_pc0", 'h00, 1, 7, 32'h00000000);
    run(10);
    @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending trace entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
